order_payload_gen: RTL and testbench
====================================

// Module: order_payload_gen
// PURPOSE
//  Multi-PE order payload packer: NUM_PE processing engines raise one-cycle requests with order fields; block snapshots them, arbitrates, emits a
//  59-byte order message as a 2-beat 256-bit AXI-Stream packet toward the network TX path. Acks each PE when its message starts.
// PARAMETERS
//  NUM_PE  10  number of requesting engines (1..16)
// PORTS
//  clk            in   1          clock; all logic on rising edge
//  reset          in   1          synchronous, active-high reset
//  session_id     in   16         header session id (common)
//  MsgSeqNum      in   32         header sequence number (common)
//  epoch_s        in   32         header time, seconds (common)
//  ms             in   16         header time, milliseconds (common)
//  cm_id          in   16         static broker id
//  investor_acno  in   32         static account number
//  investor_flag  in   8          static investor flag
//  order_source   in   8          static order source
//  PE_enable      in   NUM_PE     per-PE request pulse
//  ExecType       in   8*NUM_PE   per-PE slice i at [8i+:8] (same rule for all per-PE buses)
//  user_define    in   64*NUM_PE  user bytes 0..7, byte0 in slice MSBs
//  symbol_type    in   8*NUM_PE   symbol type
//  sym            in   160*NUM_PE 20-byte symbol
//  price          in   32*NUM_PE  price
//  qty            in   16*NUM_PE  quantity
//  side, OrdType, TimeInForce  in  8*NUM_PE each
//  PE_acks        out  NUM_PE     one-cycle ack per PE
//  tready         in   1          AXIS sink ready
//  tvalid, tlast  out  1          AXIS valid / last
//  data           out  256        AXIS data; beat byte n = data[255-8n -: 8]
//  tkeep, tstrb   out  32         byte enables (tstrb == tkeep), bit i covers data[8i+:8]
// BEHAVIOUR
//  - Capture: PE_enable[i]=1 and pending[i]=0 -> at that edge store slice i fields + session_id/MsgSeqNum/epoch_s/ms, set pending[i].
//    Enable while pending[i]=1 is ignored (no overwrite, no extra ack).
//  - Message bytes (multi-byte fields big-endian): 0 session_id, 2 MsgSeqNum, 6 epoch_s, 10 ms, 12 ExecType, 13 cm_id, 15 investor_acno,
//    19 investor_flag, 20 order_source, 21..28 user_define0..7, 29 symbol_type, 30..49 sym, 50 price, 54 qty, 56 side, 57 OrdType, 58 TimeInForce.
//  - Beat0 = bytes 0..31, tkeep 32'hFFFF_FFFF, tlast 0. Beat1 = bytes 32..58 in beat bytes 0..26, bytes 27..31 zero, tkeep 32'hFFFF_FFE0, tlast 1.
//  - FSM IDLE/BEAT0/BEAT1. IDLE & any pending: select winner, load beat0, pulse PE_acks[winner], clear pending[winner] -> BEAT0.
//    BEAT0 & tready -> load beat1 -> BEAT1. BEAT1 & tready: pending -> next winner beat0 (back-to-back, ack pulses) else IDLE.
//  - data/tkeep/tlast held stable while tvalid & !tready. tvalid=0 only in IDLE.
//  - Latency: enable at edge N (captured), tvalid+ack at edge N+1; minimum 2 cycles per message.
//  - Arbitration default: fixed priority, lowest index wins. Simultaneous enable with an ongoing grant is captured, never lost.
//  - Reset (any time, incl. mid-packet): IDLE, pending=0, tvalid=0, tlast=0, PE_acks=0, data=0, tkeep=tstrb=0; partial packet abandoned.
// CONFIGURATION
//  PAYLOAD_RR_ARB_EN defined: round-robin arbitration; search starts at index after last winner (wraps NUM_PE-1 -> 0).
//  Not defined: fixed lowest-index priority.
// TESTING
//  1. PE1 only: ExecType 8'h4d, session 0, MsgSeqNum 1, epoch 2, ms 7, cm_id 16'h00ed, tready=1 -> PE_acks=10'b10 one cycle;
//     beat0 data[255:136]=120'h0000_00000001_00000002_0007_4d_00ed; beat1 bytes 18..21=32'h0011c600, tlast=1, tkeep=32'hFFFF_FFE0.
//  2. PE0 and PE2 same cycle -> PE0 packet then PE2 packet back-to-back, acks 1 then 4, 4 valid beats contiguous
//     (RR_EN: last winner PE1 -> PE2 first).
//  3. tready=0 for 3 cycles in BEAT0 -> data/tvalid held, no beat1 until tready=1.
//  4. PE1 re-enabled while pending -> exactly one packet, one ack, original fields.
//  5. Reset asserted during BEAT1 -> next cycle tvalid=0, tlast=0, pending cleared, no further acks.
//  6. MsgSeqNum changed cycle after PE1 enable -> packet carries value captured at enable.

Source files
------------

// File: rtl/order_payload_gen.sv
// Multi-PE order payload packer: snapshots per-PE order requests, arbitrates, and streams a 59-byte message as two 256-bit AXIS beats.
// Optional macro PAYLOAD_RR_ARB_EN selects round-robin arbitration; fixed lowest-index priority otherwise.
module order_payload_gen #(
  parameter int unsigned NUM_PE = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             session_id,
  input  logic [31:0]             MsgSeqNum,
  input  logic [31:0]             epoch_s,
  input  logic [15:0]             ms,
  input  logic [15:0]             cm_id,
  input  logic [31:0]             investor_acno,
  input  logic [7:0]              investor_flag,
  input  logic [7:0]              order_source,
  input  logic [NUM_PE-1:0]       PE_enable,
  input  logic [8*NUM_PE-1:0]     ExecType,
  input  logic [64*NUM_PE-1:0]    user_define,
  input  logic [8*NUM_PE-1:0]     symbol_type,
  input  logic [160*NUM_PE-1:0]   sym,
  input  logic [32*NUM_PE-1:0]    price,
  input  logic [16*NUM_PE-1:0]    qty,
  input  logic [8*NUM_PE-1:0]     side,
  input  logic [8*NUM_PE-1:0]     OrdType,
  input  logic [8*NUM_PE-1:0]     TimeInForce,
  output logic [NUM_PE-1:0]       PE_acks,
  input  logic                    tready,
  output logic                    tvalid,
  output logic                    tlast,
  output logic [255:0]            data,
  output logic [31:0]             tkeep,
  output logic [31:0]             tstrb
);

  localparam int unsigned IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_t;

  state_t              r_state;
  logic [NUM_PE-1:0]   r_pend;
  logic [215:0]        r_beat1;

  logic [15:0]  r_sess  [NUM_PE];
  logic [31:0]  r_seq   [NUM_PE];
  logic [31:0]  r_epoch [NUM_PE];
  logic [15:0]  r_ms    [NUM_PE];
  logic [7:0]   r_exec  [NUM_PE];
  logic [63:0]  r_user  [NUM_PE];
  logic [7:0]   r_symt  [NUM_PE];
  logic [159:0] r_sym   [NUM_PE];
  logic [31:0]  r_price [NUM_PE];
  logic [15:0]  r_qty   [NUM_PE];
  logic [7:0]   r_side  [NUM_PE];
  logic [7:0]   r_ordt  [NUM_PE];
  logic [7:0]   r_tif   [NUM_PE];

  logic [IW-1:0]     w_win;
  logic              w_any;
  logic              w_grant;
  logic [NUM_PE-1:0] w_onehot;
  logic [471:0]      w_msg;

`ifdef PAYLOAD_RR_ARB_EN
  logic [IW-1:0] r_last;
  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      w_idx = IW'((32'(r_last) + 32'd1 + k) % NUM_PE);
      if (!w_found && r_pend[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end
`else
  // Descending scan so the lowest pending index is the last write.
  always_comb begin
    w_win = '0;
    for (int unsigned k = NUM_PE; k > 0; k--) begin
      if (r_pend[k-1]) w_win = IW'(k-1);
    end
  end
`endif

  assign w_any   = |r_pend;
  assign w_grant = w_any && ((r_state == S_IDLE) || (r_state == S_BEAT1 && tready));

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_win] = 1'b1;
  end

  assign w_msg = {r_sess[w_win], r_seq[w_win], r_epoch[w_win], r_ms[w_win], r_exec[w_win],
                  cm_id, investor_acno, investor_flag, order_source,
                  r_user[w_win], r_symt[w_win], r_sym[w_win], r_price[w_win], r_qty[w_win],
                  r_side[w_win], r_ordt[w_win], r_tif[w_win]};

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (PE_enable[i] && !r_pend[i]) begin
        r_sess[i]  <= session_id;
        r_seq[i]   <= MsgSeqNum;
        r_epoch[i] <= epoch_s;
        r_ms[i]    <= ms;
        r_exec[i]  <= ExecType[8*i +: 8];
        r_user[i]  <= user_define[64*i +: 64];
        r_symt[i]  <= symbol_type[8*i +: 8];
        r_sym[i]   <= sym[160*i +: 160];
        r_price[i] <= price[32*i +: 32];
        r_qty[i]   <= qty[16*i +: 16];
        r_side[i]  <= side[8*i +: 8];
        r_ordt[i]  <= OrdType[8*i +: 8];
        r_tif[i]   <= TimeInForce[8*i +: 8];
      end
    end
  end

  // A slot being granted this edge is still pending, so a same-edge enable on it is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~(w_grant ? w_onehot : '0)) | (PE_enable & ~r_pend);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      tvalid  <= 1'b0;
      tlast   <= 1'b0;
      PE_acks <= '0;
      data    <= '0;
      tkeep   <= '0;
      tstrb   <= '0;
      r_beat1 <= '0;
`ifdef PAYLOAD_RR_ARB_EN
      r_last  <= IW'(NUM_PE - 1);
`endif
    end else begin
      PE_acks <= '0;
      if (w_grant) begin
        r_state <= S_BEAT0;
        tvalid  <= 1'b1;
        tlast   <= 1'b0;
        data    <= w_msg[471:216];
        tkeep   <= '1;
        tstrb   <= '1;
        r_beat1 <= w_msg[215:0];
        PE_acks <= w_onehot;
`ifdef PAYLOAD_RR_ARB_EN
        r_last  <= w_win;
`endif
      end else begin
        case (r_state)
          S_BEAT0: begin
            if (tready) begin
              r_state <= S_BEAT1;
              tlast   <= 1'b1;
              data    <= {r_beat1, 40'h0};
              tkeep   <= 32'hFFFF_FFE0;
              tstrb   <= 32'hFFFF_FFE0;
            end
          end
          S_BEAT1: begin
            if (tready) begin
              r_state <= S_IDLE;
              tvalid  <= 1'b0;
              tlast   <= 1'b0;
              data    <= '0;
              tkeep   <= '0;
              tstrb   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_order_payload_gen.sv
// Directed self-checking bench for order_payload_gen with hand-computed expected beats.
module tb_order_payload_gen;
  localparam int unsigned NP = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic [15:0]         session_id;
  logic [31:0]         MsgSeqNum;
  logic [31:0]         epoch_s;
  logic [15:0]         ms;
  logic [15:0]         cm_id;
  logic [31:0]         investor_acno;
  logic [7:0]          investor_flag;
  logic [7:0]          order_source;
  logic [NP-1:0]       PE_enable;
  logic [8*NP-1:0]     ExecType;
  logic [64*NP-1:0]    user_define;
  logic [8*NP-1:0]     symbol_type;
  logic [160*NP-1:0]   sym;
  logic [32*NP-1:0]    price;
  logic [16*NP-1:0]    qty;
  logic [8*NP-1:0]     side;
  logic [8*NP-1:0]     OrdType;
  logic [8*NP-1:0]     TimeInForce;
  logic [NP-1:0]       PE_acks;
  logic                tready;
  logic                tvalid;
  logic                tlast;
  logic [255:0]        data;
  logic [31:0]         tkeep;
  logic [31:0]         tstrb;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] EXP_B0 = {120'h0000_00000001_00000002_0007_4d_00ed, 32'h12345678, 8'h01, 8'h02,
                                     64'hA0A1A2A3A4A5A6A7, 8'h53, 16'h4142};
  localparam logic [255:0] EXP_B1 = {144'h434445464748494A4B4C4D4E4F5051525354, 32'h0011c600, 16'h0064,
                                     8'h31, 8'h32, 8'h33, 40'h0};

`ifdef PAYLOAD_RR_ARB_EN
  localparam logic [NP-1:0] F_ACK = 10'b100;
  localparam logic [7:0]    F_EX  = 8'h12;
  localparam logic [31:0]   F_PR  = 32'h300;
  localparam logic [NP-1:0] S_ACK = 10'b001;
  localparam logic [7:0]    S_EX  = 8'h10;
  localparam logic [31:0]   S_PR  = 32'h100;
`else
  localparam logic [NP-1:0] F_ACK = 10'b001;
  localparam logic [7:0]    F_EX  = 8'h10;
  localparam logic [31:0]   F_PR  = 32'h100;
  localparam logic [NP-1:0] S_ACK = 10'b100;
  localparam logic [7:0]    S_EX  = 8'h12;
  localparam logic [31:0]   S_PR  = 32'h300;
`endif

  order_payload_gen #(.NUM_PE(NP)) dut (
    .clk(clk), .reset(reset), .session_id(session_id), .MsgSeqNum(MsgSeqNum), .epoch_s(epoch_s), .ms(ms),
    .cm_id(cm_id), .investor_acno(investor_acno), .investor_flag(investor_flag), .order_source(order_source),
    .PE_enable(PE_enable), .ExecType(ExecType), .user_define(user_define), .symbol_type(symbol_type),
    .sym(sym), .price(price), .qty(qty), .side(side), .OrdType(OrdType), .TimeInForce(TimeInForce),
    .PE_acks(PE_acks), .tready(tready), .tvalid(tvalid), .tlast(tlast), .data(data), .tkeep(tkeep),
    .tstrb(tstrb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pe(input int unsigned i, input logic [7:0] ex, input logic [31:0] pr);
    ExecType[8*i +: 8]  = ex;
    price[32*i +: 32]   = pr;
  endtask

  function automatic logic [119:0] hdr(input logic [31:0] seq, input logic [7:0] ex);
    return {16'h0000, seq, 32'd2, 16'd7, ex, 16'h00ed};
  endfunction

  initial begin
    reset = 1'b1; tready = 1'b1; PE_enable = '0;
    session_id = 16'h0; MsgSeqNum = 32'd1; epoch_s = 32'd2; ms = 16'd7;
    cm_id = 16'h00ed; investor_acno = 32'h12345678; investor_flag = 8'h01; order_source = 8'h02;
    ExecType = '0; user_define = '0; symbol_type = '0; sym = '0; price = '0; qty = '0;
    side = '0; OrdType = '0; TimeInForce = '0;
    tick(); tick();
    check("rst_tvalid", 256'(tvalid), 256'(1'b0));
    check("rst_tlast", 256'(tlast), 256'(1'b0));
    check("rst_acks", 256'(PE_acks), 256'(10'b0));
    check("rst_data", data, 256'h0);
    check("rst_tkeep", 256'({tkeep, tstrb}), 256'(64'h0));
    reset = 1'b0;

    // PE1 single message; MsgSeqNum changes right after capture
    ExecType[15:8] = 8'h4d; user_define[127:64] = 64'hA0A1A2A3A4A5A6A7; symbol_type[15:8] = 8'h53;
    sym[319:160] = 160'h4142434445464748494A4B4C4D4E4F5051525354; price[63:32] = 32'h0011c600;
    qty[31:16] = 16'h0064; side[15:8] = 8'h31; OrdType[15:8] = 8'h32; TimeInForce[15:8] = 8'h33;
    PE_enable = 10'b10;
    tick();
    PE_enable = '0; MsgSeqNum = 32'hDEADBEEF;
    check("t1_idle_after_cap", 256'(tvalid), 256'(1'b0));
    tick();
    check("t1_ack", 256'(PE_acks), 256'(10'b10));
    check("t1_b0_valid", 256'({tvalid, tlast}), 256'(2'b10));
    check("t1_b0_keep", 256'({tkeep, tstrb}), 256'(64'hFFFFFFFF_FFFFFFFF));
    check("t1_b0_data", data, EXP_B0);
    tick();
    check("t1_ack_off", 256'(PE_acks), 256'(10'b0));
    check("t1_b1_valid", 256'({tvalid, tlast}), 256'(2'b11));
    check("t1_b1_keep", 256'({tkeep, tstrb}), 256'(64'hFFFFFFE0_FFFFFFE0));
    check("t1_b1_data", data, EXP_B1);
    check("t1_b1_price", 256'(data[111:80]), 256'(32'h0011c600));
    tick();
    check("t1_end", 256'(tvalid), 256'(1'b0));

    // PE0+PE2 together; PE2 re-enabled with new fields while pending
    MsgSeqNum = 32'd5;
    set_pe(0, 8'h10, 32'h100); set_pe(2, 8'h12, 32'h300);
    PE_enable = 10'b101;
    tick();
    PE_enable = 10'b100; set_pe(2, 8'h99, 32'h999);
    tick();
    PE_enable = '0;
    check("t2_p1_ack", 256'(PE_acks), 256'(F_ACK));
    check("t2_p1_hdr", 256'(data[255:136]), 256'(hdr(32'd5, F_EX)));
    check("t2_p1_b0", 256'({tvalid, tlast}), 256'(2'b10));
    tick();
    check("t2_p1_b1", 256'({tvalid, tlast}), 256'(2'b11));
    check("t2_p1_price", 256'(data[111:80]), 256'(F_PR));
    tick();
    check("t2_p2_ack", 256'(PE_acks), 256'(S_ACK));
    check("t2_p2_b0", 256'({tvalid, tlast}), 256'(2'b10));
    check("t2_p2_hdr", 256'(data[255:136]), 256'(hdr(32'd5, S_EX)));
    tick();
    check("t2_p2_b1", 256'({tvalid, tlast}), 256'(2'b11));
    check("t2_p2_price", 256'(data[111:80]), 256'(S_PR));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_no_extra", 256'({tvalid, PE_acks}), 256'(11'b0));
    end

    // Backpressure in BEAT0
    MsgSeqNum = 32'd6; set_pe(3, 8'h13, 32'h333);
    PE_enable = 10'b1000;
    tick();
    PE_enable = '0;
    tick();
    check("t3_ack", 256'(PE_acks), 256'(10'b1000));
    check("t3_hdr", 256'(data[255:136]), 256'(hdr(32'd6, 8'h13)));
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_ctl", 256'({tvalid, tlast, tkeep}), 256'({2'b10, 32'hFFFFFFFF}));
      check("t3_hold_hdr", 256'(data[255:136]), 256'(hdr(32'd6, 8'h13)));
    end
    tready = 1'b1;
    tick();
    check("t3_b1", 256'({tvalid, tlast}), 256'(2'b11));
    check("t3_price", 256'(data[111:80]), 256'(32'h333));
    tick();
    check("t3_end", 256'(tvalid), 256'(1'b0));

    // Reset during BEAT1 with another PE pending
    set_pe(4, 8'h14, 32'h444); set_pe(5, 8'h15, 32'h555);
    PE_enable = 10'b10000;
    tick();
    PE_enable = 10'b100000;
    tick();
    PE_enable = '0;
    check("t5_b0_ack", 256'(PE_acks), 256'(10'b10000));
    tick();
    check("t5_in_b1", 256'({tvalid, tlast}), 256'(2'b11));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_ctl", 256'({tvalid, tlast, PE_acks}), 256'(12'b0));
    check("t5_rst_data", data, 256'h0);
    check("t5_rst_keep", 256'({tkeep, tstrb}), 256'(64'h0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_quiet", 256'({tvalid, PE_acks}), 256'(11'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
